// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (address, word count, payload,
// checksum) and turns it into little-endian program-memory word writes.
// A mod-256 sum of header and payload bytes is compared against the
// trailing checksum byte, and a mismatch raises a sticky error flag.
module prog_loader #(
    parameter int BIT_WIDTH = 16,
    parameter int BYTES     = BIT_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [15:0]          wr_addr,
    output logic [BIT_WIDTH-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_written
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CSUM
    } state_t;

    // Byte position of the final byte of a payload word.
    localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);

    state_t                r_state;
    state_t                w_next_state;

    logic [2:0]            r_byte_idx;      // header byte 0..3, or byte within word
    logic [15:0]           r_addr_base;     // ADDR field
    logic [15:0]           r_cnt;           // CNT field
    logic [15:0]           r_word_idx;      // words completed in this frame
    logic [7:0]            r_sum;           // running mod-256 sum
    logic [BIT_WIDTH-1:0]  r_data_buf;      // bytes of the word being assembled

    logic                  r_wr_en;
    logic [15:0]           r_wr_addr;
    logic [BIT_WIDTH-1:0]  r_wr_data;
    logic                  r_done;
    logic                  r_error;
    logic [15:0]           r_words_written;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_word_done;
    logic                  w_last_word;
    logic [BIT_WIDTH-1:0]  w_word;

    // Handshake and frame-position decode.
    assign w_in_ready  = (r_state != IDLE);
    assign w_accept    = in_valid && w_in_ready && !abort;
    assign w_start_ok  = (r_state == IDLE) && start && !abort;
    assign w_word_done = (r_byte_idx == LAST_BYTE);
    assign w_last_word = (r_word_idx == (r_cnt - 16'd1));

    // Completed word: buffered low bytes with the incoming byte on top.
    always_comb begin
        w_word = r_data_buf;
        w_word[BIT_WIDTH-8 +: 8] = in_data;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every sequential process uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational;
        // a path that left w_next_state unassigned would infer a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = HDR;
                end
            end
            HDR: begin
                if (w_accept && (r_byte_idx == 3'd3)) begin
                    if ({in_data, r_cnt[7:0]} != 16'd0) begin
                        w_next_state = DATA;
                    end else begin
                        w_next_state = CSUM;
                    end
                end
            end
            DATA: begin
                if (w_accept && w_word_done && w_last_word) begin
                    w_next_state = CSUM;
                end
            end
            CSUM: begin
                if (w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (abort) begin
            w_next_state = IDLE;
        end
    end

    // Frame datapath: header capture, word assembly, write strobe, checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx      <= 3'd0;
            r_addr_base     <= 16'd0;
            r_cnt           <= 16'd0;
            r_word_idx      <= 16'd0;
            r_sum           <= 8'd0;
            r_data_buf      <= '0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= 16'd0;
            r_wr_data       <= '0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= 16'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (w_start_ok) begin
                r_byte_idx      <= 3'd0;
                r_word_idx      <= 16'd0;
                r_sum           <= 8'd0;
                r_error         <= 1'b0;
                r_words_written <= 16'd0;
            end else if (w_accept) begin
                case (r_state)
                    HDR: begin
                        r_sum <= r_sum + in_data;
                        case (r_byte_idx)
                            3'd0:    r_addr_base[7:0]  <= in_data;
                            3'd1:    r_addr_base[15:8] <= in_data;
                            3'd2:    r_cnt[7:0]        <= in_data;
                            default: r_cnt[15:8]       <= in_data;
                        endcase
                        if (r_byte_idx == 3'd3) begin
                            r_byte_idx <= 3'd0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                    DATA: begin
                        r_sum <= r_sum + in_data;
                        if (w_word_done) begin
                            r_wr_en         <= 1'b1;
                            r_wr_addr       <= r_addr_base + r_word_idx;
                            r_wr_data       <= w_word;
                            r_words_written <= r_words_written + 16'd1;
                            r_word_idx      <= r_word_idx + 16'd1;
                            r_byte_idx      <= 3'd0;
                        end else begin
                            r_data_buf[{r_byte_idx, 3'b000} +: 8] <= in_data;
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                    CSUM: begin
                        r_done <= 1'b1;
                        if (in_data != r_sum) begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign busy          = (r_state != IDLE);
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (BIT_WIDTH=16): nominal, wrap/checksum
// failure, empty frame, backpressure, abort, and mid-frame reset.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int n_tests = 0;
    int n_fail  = 0;

    // Write/done log gathered by the monitor.
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    int          done_cnt = 0;
    logic        rdy_bad  = 1'b0;

    prog_loader #(.BIT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (done) done_cnt++;
        if (busy && !in_ready) rdy_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
        rdy_bad  = 1'b0;
    endtask

    // Pulse start for one cycle (called 1 time unit after an edge).
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and wait for it to be accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int k;
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Send n bytes, right-justified in f, first byte most significant.
    // hold_start keeps start high while busy, except during the final byte.
    task automatic send_frame(input logic [127:0] f, input int n, input int gap,
                              input logic hold_start);
        for (int i = 0; i < n; i++) begin
            start = hold_start && (i < n - 1);
            send_byte(f[8*(n-1-i) +: 8]);
            if (gap > 0 && i < n - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_nominal(input string p);
        check({p, "_nwr"},   32'(log_addr.size()), 32'd2);
        check({p, "_a0"},    {16'd0, log_addr[0]}, 32'h0100);
        check({p, "_d0"},    {16'd0, log_data[0]}, 32'h1234);
        check({p, "_a1"},    {16'd0, log_addr[1]}, 32'h0101);
        check({p, "_d1"},    {16'd0, log_data[1]}, 32'h5678);
        check({p, "_done"},  {31'd0, done},  32'd1);
        check({p, "_idle"},  {31'd0, busy},  32'd0);
        check({p, "_err"},   {31'd0, error}, 32'd0);
        check({p, "_ww"},    {16'd0, words_written}, 32'd2);
        @(posedge clk); #1;
        check({p, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({p, "_ndone"},     32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_wr_en",    {31'd0, wr_en},    32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_error",    {31'd0, error},    32'd0);
        check("rst_wr_addr",  {16'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {16'd0, wr_data},  32'd0);
        check("rst_ww",       {16'd0, words_written}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal frame.
        clear_log();
        do_start();
        check("nom_busy",     {31'd0, busy},     32'd1);
        check("nom_in_ready", {31'd0, in_ready}, 32'd1);
        send_frame(128'h00_01_02_00_34_12_78_56_17, 9, 0, 1'b0);
        check_nominal("nom");
        check("hold_addr", {16'd0, wr_addr}, 32'h0101);
        check("hold_data", {16'd0, wr_data}, 32'h5678);

        // Address wrap and checksum failure (correct sum would be 0x66).
        clear_log();
        do_start();
        send_frame(128'hFF_FF_02_00_11_11_22_22_00, 9, 0, 1'b0);
        check("wrap_nwr",  32'(log_addr.size()), 32'd2);
        check("wrap_a0",   {16'd0, log_addr[0]}, 32'hFFFF);
        check("wrap_d0",   {16'd0, log_data[0]}, 32'h1111);
        check("wrap_a1",   {16'd0, log_addr[1]}, 32'h0000);
        check("wrap_d1",   {16'd0, log_data[1]}, 32'h2222);
        check("wrap_done", {31'd0, done},  32'd1);
        check("wrap_err",  {31'd0, error}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", {31'd0, error}, 32'd1);
        check("wrap_ndone", 32'(done_cnt), 32'd1);

        // Empty frame; start must also clear the sticky error.
        clear_log();
        do_start();
        check("start_clr_err", {31'd0, error}, 32'd0);
        send_frame(128'h10_00_00_00_10, 5, 0, 1'b0);
        check("empty_nwr",  32'(log_addr.size()), 32'd0);
        check("empty_done", {31'd0, done},  32'd1);
        check("empty_err",  {31'd0, error}, 32'd0);
        check("empty_ww",   {16'd0, words_written}, 32'd0);

        // Backpressure, with start held high while busy (must be ignored).
        @(posedge clk); #1;
        clear_log();
        do_start();
        send_frame(128'h00_01_02_00_34_12_78_56_17, 9, 3, 1'b1);
        check_nominal("bp");
        check("bp_in_ready", {31'd0, rdy_bad}, 32'd0);

        // Abort after byte 34; start pulsed in DATA alongside that byte.
        clear_log();
        do_start();
        send_frame(128'h00_01_02_00, 4, 0, 1'b1);
        start = 1'b1;
        send_byte(8'h34);
        start = 1'b0;
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h12;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_idle",  {31'd0, busy},     32'd0);
        check("abort_rdy",   {31'd0, in_ready}, 32'd0);
        check("abort_wr_en", {31'd0, wr_en},    32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_nwr",   32'(log_addr.size()), 32'd0);
        check("abort_ndone", 32'(done_cnt), 32'd0);
        check("abort_err",   {31'd0, error}, 32'd0);
        check("abort_ww",    {16'd0, words_written}, 32'd0);

        // Reset right after the first payload word is written.
        clear_log();
        do_start();
        send_frame(128'h00_01_02_00_34_12, 6, 0, 1'b0);
        check("mr_wr_en_pre", {31'd0, wr_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_wr_en",   {31'd0, wr_en},    32'd0);
        check("mr_busy",    {31'd0, busy},     32'd0);
        check("mr_rdy",     {31'd0, in_ready}, 32'd0);
        check("mr_wr_addr", {16'd0, wr_addr},  32'd0);
        check("mr_wr_data", {16'd0, wr_data},  32'd0);
        check("mr_ww",      {16'd0, words_written}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'h78;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mr_no_wr",   32'(log_addr.size()), 32'd0);
        check("mr_no_done", 32'(done_cnt), 32'd0);

        // Clean frame after the reset.
        clear_log();
        do_start();
        send_frame(128'h00_01_02_00_34_12_78_56_17, 9, 0, 1'b0);
        check_nominal("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
